// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// muldiv_sequencer: bit-serial RV32M multiply/divide for the Execute stage.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit
// per cycle. Divide-by-zero and signed overflow finish on a fast path.
module muldiv_sequencer #(
   parameter int unsigned CPU_DATA_BITS = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     s2_valid,
   input  logic [6:0]               s2_opcode,
   input  logic [2:0]               s2_func,
   input  logic                     s2_funct7_md,
   input  logic [CPU_DATA_BITS-1:0] s2_rs1_data,
   input  logic [CPU_DATA_BITS-1:0] s2_rs2_data,
   output logic                     s2_md_stall,
   output logic                     s2_md_valid,
   output logic [CPU_DATA_BITS-1:0] s2_md_result
);

   localparam int unsigned W  = CPU_DATA_BITS;
   localparam int unsigned CW = 5;
   localparam logic [6:0]    OPC_ARI_RTYPE = 7'b0110011;
   localparam logic [CW-1:0] CNT_LAST      = CW'(31);
   localparam logic [W-1:0]  INT_MIN       = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    opnd_q, opnd_d;
   logic            neg_q, neg_d;
   logic            rneg_q, rneg_d;
   logic            div_q, div_d;
   logic [1:0]      fn_q, fn_d;
   logic [W-1:0]    res_q, res_d;
   logic            stall_c;

   // Request decode, operand magnitudes and fast-path detection
   logic            md_req, is_div, rs1_neg, rs2_neg, div_zero, div_ovf, fast;
   logic [W-1:0]    a_mag, b_mag, fast_res;

   assign md_req   = s2_valid && (s2_opcode == OPC_ARI_RTYPE) && s2_funct7_md;
   assign is_div   = s2_func[2];
   // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 for MUL/MULH/DIV/REM
   assign rs1_neg  = s2_rs1_data[W-1] && (is_div ? !s2_func[0] : (s2_func[1:0] != 2'b11));
   assign rs2_neg  = s2_rs2_data[W-1] && (is_div ? !s2_func[0] : !s2_func[1]);
   assign a_mag    = rs1_neg ? -s2_rs1_data : s2_rs1_data;
   assign b_mag    = rs2_neg ? -s2_rs2_data : s2_rs2_data;
   assign div_zero = is_div && (s2_rs2_data == '0);
   assign div_ovf  = is_div && !s2_func[0] && (s2_rs1_data == INT_MIN) && (s2_rs2_data == '1);
   assign fast     = div_zero || div_ovf;
   assign fast_res = div_zero ? (s2_func[1] ? s2_rs1_data : '1)
                              : (s2_func[1] ? '0 : INT_MIN);

   // One iteration of the shared accumulator (multiply or divide step)
   logic [W:0]      mul_sum, sh_hi;
   logic [2*W-1:0]  mul_nxt, div_nxt, acc_nxt, prod;
   logic [W-1:0]    quo, rem, calc_res;
   logic            ge;

   assign mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
   assign mul_nxt = {mul_sum, acc_q[W-1:1]};
   assign sh_hi   = acc_q[2*W-1:W-1];
   assign ge      = (sh_hi >= {1'b0, opnd_q});
   assign div_nxt = ge ? {sh_hi[W-1:0] - opnd_q, acc_q[W-2:0], 1'b1}
                       : {acc_q[2*W-2:0], 1'b0};
   assign acc_nxt = div_q ? div_nxt : mul_nxt;

   // Sign correction of the final iteration's result
   assign prod     = neg_q ? -acc_nxt : acc_nxt;
   assign quo      = neg_q ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
   assign rem      = rneg_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
   assign calc_res = div_q ? (fn_q[1] ? rem : quo)
                           : ((fn_q == 2'b00) ? prod[W-1:0] : prod[2*W-1:W]);

   // Next-state, datapath load and stall decision
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      div_d   = div_q;
      fn_d    = fn_q;
      res_d   = res_q;
      stall_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (md_req) begin
               stall_c = 1'b1;
               if (fast) begin
                  res_d   = fast_res;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
                  cnt_d   = '0;
                  acc_d   = is_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                  opnd_d  = is_div ? b_mag : a_mag;
                  neg_d   = rs1_neg ^ rs2_neg;
                  rneg_d  = rs1_neg;
                  div_d   = is_div;
                  fn_d    = s2_func[1:0];
               end
            end
         end
         S_CALC: begin
            stall_c = 1'b1;
            acc_d   = acc_nxt;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               res_d   = calc_res;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            res_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div_q   <= 1'b0;
         fn_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div_q   <= div_d;
         fn_q    <= fn_d;
         res_q   <= res_d;
      end
   end

   // A cycle with reset held never stalls the pipeline
   assign s2_md_stall  = stall_c && !reset;
   assign s2_md_valid  = (state_q == S_DONE);
   assign s2_md_result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
// Testbench for muldiv_sequencer: directed and random RV32M ops against an
// arithmetic reference model, plus reset, fast-path and non-M checks.
module tb_muldiv_sequencer;

   localparam logic [6:0] RTYPE = 7'b0110011;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s2_valid = 1'b0;
   logic [6:0]  s2_opcode = 7'd0;
   logic [2:0]  s2_func = 3'd0;
   logic        s2_funct7_md = 1'b0;
   logic [31:0] s2_rs1_data = 32'd0;
   logic [31:0] s2_rs2_data = 32'd0;
   logic        s2_md_stall;
   logic        s2_md_valid;
   logic [31:0] s2_md_result;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .s2_valid     (s2_valid),
      .s2_opcode    (s2_opcode),
      .s2_func      (s2_func),
      .s2_funct7_md (s2_funct7_md),
      .s2_rs1_data  (s2_rs1_data),
      .s2_rs2_data  (s2_rs2_data),
      .s2_md_stall  (s2_md_stall),
      .s2_md_valid  (s2_md_valid),
      .s2_md_result (s2_md_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result straight from the RV32M definitions
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      int              ia, ib;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Follow an op issued in the current cycle until its valid strobe
   task automatic wait_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] exp;
      bit          fast;
      int          n_stall, cyc;
      exp  = model(f, a, b);
      fast = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      chk({tag, ":issue_valid"}, 32'(s2_md_valid), 32'd0);
      n_stall = 0;
      cyc     = 0;
      while (!s2_md_valid && cyc < 40) begin
         if (s2_md_stall) n_stall++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, ":timeout"}, 32'(cyc < 40), 32'd1);
      chk({tag, ":stall_cycles"}, 32'(n_stall), fast ? 32'd1 : 32'd33);
      chk({tag, ":result"}, s2_md_result, exp);
      chk({tag, ":done_stall"}, 32'(s2_md_stall), 32'd0);
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      s2_valid     = 1'b1;
      s2_opcode    = RTYPE;
      s2_funct7_md = 1'b1;
      s2_func      = f;
      s2_rs1_data  = a;
      s2_rs2_data  = b;
      #1;
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
      issue(f, a, b);
      wait_result(f, a, b, tag);
   endtask

   task automatic quiet_cycles(input string tag);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, ":stall"}, 32'(s2_md_stall), 32'd0);
         chk({tag, ":valid"}, 32'(s2_md_valid), 32'd0);
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] specials [4];
      specials[0] = 32'd0;
      specials[1] = 32'h8000_0000;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'd1;
      if ($urandom_range(3) == 0) return specials[$urandom_range(3)];
      return $urandom;
   endfunction

   initial begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset:stall", 32'(s2_md_stall), 32'd0);
      chk("reset:valid", 32'(s2_md_valid), 32'd0);
      chk("reset:result", s2_md_result, 32'd0);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
      run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
      run_op(3'd5, 32'd5, 32'd0, "divu_by0");
      run_op(3'd6, 32'd5, 32'd0, "rem_by0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

      // Reset in the CALC cycle where the counter holds 10
      issue(3'd0, 32'd12345, 32'd678);
      repeat (11) @(negedge clk);
      chk("midreset:pre_stall", 32'(s2_md_stall), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset:stall", 32'(s2_md_stall), 32'd0);
      chk("midreset:valid", 32'(s2_md_valid), 32'd0);
      chk("midreset:result", s2_md_result, 32'd0);
      reset = 1'b0;
      #1;
      wait_result(3'd0, 32'd12345, 32'd678, "after_reset");

      // Back-to-back MUL then DIV, then non-M traffic
      run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, "b2b_mul");
      run_op(3'd4, 32'h8765_4321, 32'd1000, "b2b_div");
      s2_funct7_md = 1'b0;
      s2_func      = 3'd0;
      quiet_cycles("add");
      s2_valid     = 1'b0;
      s2_funct7_md = 1'b1;
      quiet_cycles("invalid_m");

      for (int i = 0; i < 24; i++) begin
         rf = 3'($urandom_range(7));
         ra = pick();
         rb = pick();
         run_op(rf, ra, rb, $sformatf("rand%0d_f%0d", i, rf));
      end

      s2_valid = 1'b0;
      @(negedge clk);
      chk("final:valid", 32'(s2_md_valid), 32'd0);
      chk("final:result", s2_md_result, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
